// File: rtl/mul_result_stage.sv
// mul_result_stage: flags, 64/32-bit results and a small FIFO between the Booth core and writeback.
// Define MUL_RES_SAT_EN to saturate res32 on signed 32-bit overflow; the default build wraps.
module mul_result_stage #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        clr,
    input  logic        prod_valid,
    input  logic [66:0] prod_in,
    output logic        prod_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] res64,
    output logic [31:0] res32,
    output logic        flag_zero,
    output logic        flag_neg,
    output logic        flag_ovf32,
    output logic        flag_ext,
    output logic        ovr_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [67:0]   mem_q [DEPTH];
    logic [67:0]   mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovr_err_q, ovr_err_d;
    logic          full, push, pop;
    logic [3:0]    in_flags;
    logic [67:0]   head;

    assign res_valid  = count_q != '0;
    assign full       = count_q == CW'(DEPTH);
    assign prod_ready = !full;
    assign ovr_err    = ovr_err_q;

    always_comb begin
        pop      = res_valid && res_ready;
        push     = prod_valid && (!full || pop);
        in_flags = {!(&prod_in[66:63] || ~|prod_in[66:63]),
                    !(&prod_in[63:31] || ~|prod_in[63:31]),
                    prod_in[63],
                    prod_in[63:0] == 64'd0};
        mem_d = mem_q;
        if (push && !clr) mem_d[wr_ptr_q] = {in_flags, prod_in[63:0]};
        rd_ptr_d  = clr ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d  = clr ? '0 : wr_ptr_q + AW'(push);
        count_d   = clr ? '0 : count_q + CW'(push) - CW'(pop);
        // A product arriving while full with no pop is lost; remember it until flushed.
        ovr_err_d = !clr && (ovr_err_q || (prod_valid && full && !pop));
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            ovr_err_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            ovr_err_q <= ovr_err_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head       = mem_q[rd_ptr_q];
    assign res64      = head[63:0];
    assign flag_zero  = head[64];
    assign flag_neg   = head[65];
    assign flag_ovf32 = head[66];
    assign flag_ext   = head[67];

`ifdef MUL_RES_SAT_EN
    assign res32 = flag_ovf32 ? (flag_neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : head[31:0];
`else
    assign res32 = head[31:0];
`endif

endmodule

// File: tb/tb_mul_result_stage.sv
// tb_mul_result_stage: directed and randomized checks of mul_result_stage against a queue model.
module tb_mul_result_stage;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        clr = 1'b0;
    logic        prod_valid = 1'b0;
    logic [66:0] prod_in = '0;
    logic        res_ready = 1'b0;
    logic        prod_ready, res_valid, flag_zero, flag_neg, flag_ovf32, flag_ext, ovr_err;
    logic [63:0] res64;
    logic [31:0] res32;

    int errs = 0;
    int checks = 0;
    logic [66:0] q[$];
    bit ovr_m = 1'b0;

    mul_result_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_b(rst_b), .clr(clr), .prod_valid(prod_valid), .prod_in(prod_in),
        .prod_ready(prod_ready), .res_valid(res_valid), .res_ready(res_ready),
        .res64(res64), .res32(res32), .flag_zero(flag_zero), .flag_neg(flag_neg),
        .flag_ovf32(flag_ovf32), .flag_ext(flag_ext), .ovr_err(ovr_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Flags from the numeric value of the product, not its bit patterns.
    function automatic logic [3:0] model_flags(input logic [66:0] p);
        logic signed [66:0] s;
        logic signed [63:0] v;
        logic ext, ovf;
        s = p;
        v = p[63:0];
        ext = (s > 67'sh0_7FFF_FFFF_FFFF_FFFF) || (s < -67'sh0_8000_0000_0000_0000);
        ovf = (v > 64'sd2147483647) || (v < -64'sd2147483648);
        return {ext, ovf, v < 0, v == 0};
    endfunction

    function automatic logic [31:0] model_res32(input logic [66:0] p);
        logic [3:0] f;
        f = model_flags(p);
`ifdef MUL_RES_SAT_EN
        if (f[2]) return f[1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return p[31:0] + 32'd0 * f[0];
    endfunction

    task automatic check_outputs();
        check("res_valid", res_valid, q.size() != 0);
        check("prod_ready", prod_ready, q.size() < DEPTH);
        check("ovr_err", ovr_err, ovr_m);
        if (q.size() != 0) begin
            check("res64", res64, q[0][63:0]);
            check("res32", res32, model_res32(q[0]));
            check("flags", {flag_ext, flag_ovf32, flag_neg, flag_zero}, model_flags(q[0]));
        end
    endtask

    task automatic step(input bit c, input bit pv, input logic [66:0] p, input bit rr);
        bit pop_m;
        clr = c;
        prod_valid = pv;
        prod_in = p;
        res_ready = rr;
        check_outputs();
        @(posedge clk);
        if (c) begin
            q.delete();
            ovr_m = 1'b0;
        end else begin
            pop_m = q.size() != 0 && rr;
            if (pv && q.size() == DEPTH && !pop_m) ovr_m = 1'b1;
            else if (pv && pop_m) begin
                void'(q.pop_front());
                q.push_back(p);
            end else if (pv) q.push_back(p);
            else if (pop_m) void'(q.pop_front());
        end
        #1;
    endtask

    function automatic logic [66:0] rand_prod();
        logic [66:0] p;
        logic [63:0] w;
        int sel;
        sel = $urandom_range(0, 3);
        w = {$urandom, $urandom};
        p = {$urandom, $urandom, $urandom};
        if (sel == 0) p = {{35{w[31]}}, w[31:0]};
        else if (sel == 1) p = {{3{w[63]}}, w};
        else if (sel == 2) p = 67'($urandom_range(0, 3));
        return p;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_prod_ready", prod_ready, 1'b1);
        check("rst_ovr_err", ovr_err, 1'b0);
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        step(0, 1, 67'd6, 1);
        check("basic_valid", res_valid, 1'b1);
        check("basic_res64", res64, 64'd6);
        check("basic_res32", res32, 32'd6);
        check("basic_flags", {flag_ext, flag_ovf32, flag_neg, flag_zero}, 4'b0000);
        step(0, 0, 67'd0, 1);
        check("basic_drain", res_valid, 1'b0);

        step(0, 1, {67{1'b1}}, 1);
        check("neg_res64", res64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("neg_res32", res32, 32'hFFFF_FFFF);
        check("neg_flags", {flag_ext, flag_ovf32, flag_neg}, 3'b001);
        step(0, 0, 67'd0, 1);

        step(0, 1, 67'h1_0000_0000, 1);
        check("ovf_flag", flag_ovf32, 1'b1);
        check("ovf_res64", res64, 64'h1_0000_0000);
`ifdef MUL_RES_SAT_EN
        check("ovf_res32", res32, 32'h7FFF_FFFF);
`else
        check("ovf_res32", res32, 32'h0);
`endif
        step(0, 0, 67'd0, 1);

        step(0, 1, 67'd5, 0);
        step(0, 1, 67'd7, 0);
        check("bp_full", prod_ready, 1'b0);
        step(0, 1, 67'd9, 0);
        check("bp_ovr", ovr_err, 1'b1);
        check("bp_head0", res64, 64'd5);
        step(0, 0, 67'd0, 1);
        check("bp_head1", res64, 64'd7);
        step(0, 0, 67'd0, 1);
        check("bp_empty", res_valid, 1'b0);
        step(1, 0, 67'd0, 0);
        check("clr_ovr", ovr_err, 1'b0);

        step(0, 1, 67'd5, 0);
        step(0, 1, 67'd7, 0);
        step(0, 1, 67'd9, 1);
        check("pp_head1", res64, 64'd7);
        check("pp_no_ovr", ovr_err, 1'b0);
        step(0, 0, 67'd0, 1);
        check("pp_head2", res64, 64'd9);
        step(0, 0, 67'd0, 1);

        step(0, 1, 67'h4_0000_0000_0000_0000, 0);
        check("ext_flag", flag_ext, 1'b1);
        step(0, 1, 67'd2, 0);
        step(0, 1, 67'd3, 0);
        check("pre_clr_ovr", ovr_err, 1'b1);
        step(1, 1, 67'd123, 0);
        check("clr_empty", res_valid, 1'b0);
        check("clr_ovr2", ovr_err, 1'b0);
        step(0, 0, 67'd0, 1);
        check("clr_not_stored", res_valid, 1'b0);

        step(0, 1, 67'd1, 0);
        step(0, 1, 67'd2, 0);
        check("pre_rst_valid", res_valid, 1'b1);
        #2 rst_b = 1'b0;
        #1;
        check("arst_valid", res_valid, 1'b0);
        check("arst_ready", prod_ready, 1'b1);
        q.delete();
        ovr_m = 1'b0;
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 40) == 0, $urandom_range(0, 2) != 0, rand_prod(), $urandom_range(0, 2) != 0);
        check_outputs();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
